// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks.
// Holds the transmitter/receiver FSM state encoding, the parity mode
// constants used by the PARITY parameter, and the oversampling factor
// (ticks per bit period).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator shared by the UART transmitter and receiver.
// A mod-DVSR counter that pulses s_tick for one clk when it reaches DVSR-1.
//
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous active-high reset (counter -> 0)
//   clr     in   synchronous clear; holds the counter at 0 and masks s_tick
//   s_tick  out  one-clk pulse every DVSR clks while clr is low
module uart_baud_gen #(
    parameter int DVSR = 54
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic s_tick
);

    localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DVSR - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clr || count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign s_tick = ~clr & (count_reg == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter draining a first-word-fall-through byte FIFO.
// Pops one word whenever the line is idle and the FIFO is non-empty, then
// sends start bit, DBIT data bits LSB-first, optional parity, stop period.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-high reset
//   fifo_empty    in   FIFO empty flag
//   fifo_data     in   FIFO head word, valid while fifo_empty=0
//   fifo_rd       out  pop strobe, one clk per byte (only in IDLE)
//   tx            out  serial line, idle high, registered
//   tx_busy       out  high while a frame is in progress
//   tx_done_tick  out  one-clk pulse in the last clk of each frame
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0,
    parameter int DVSR    = 54
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    // Tick counter must reach the longer of a bit period and the stop period.
    localparam int TICK_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
    localparam int TW       = $clog2(TICK_MAX);
    localparam int BW       = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [TW-1:0] LAST_BIT_TICK  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] LAST_STOP_TICK = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] LAST_BIT       = BW'(DBIT - 1);
    localparam logic          ODD_BIT        = (PARITY == PAR_ODD);
    localparam logic          HAS_PARITY     = (PARITY != PAR_NONE);

    state_t          state_reg;
    logic [TW-1:0]   tick_cnt_reg;
    logic [BW-1:0]   bit_cnt_reg;
    logic [DBIT-1:0] shift_reg;
    logic            par_reg;
    logic            tx_reg;
    logic            s_tick;

    // Divider is held at 0 while idle so the start bit lasts a full period.
    uart_baud_gen #(
        .DVSR(DVSR)
    ) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (state_reg == IDLE),
        .s_tick(s_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            par_reg      <= 1'b0;
            tx_reg       <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (!fifo_empty) begin
                        shift_reg    <= fifo_data;
                        // Parity taken from the whole word now; the shift
                        // register is consumed bit by bit later.
                        par_reg      <= (^fifo_data) ^ ODD_BIT;
                        tick_cnt_reg <= '0;
                        state_reg    <= START;
                    end
                end
                START: begin
                    tx_reg <= 1'b0;
                    if (s_tick) begin
                        if (tick_cnt_reg == LAST_BIT_TICK) begin
                            tick_cnt_reg <= '0;
                            bit_cnt_reg  <= '0;
                            state_reg    <= DATA;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + TW'(1);
                        end
                    end
                end
                DATA: begin
                    tx_reg <= shift_reg[0];
                    if (s_tick) begin
                        if (tick_cnt_reg == LAST_BIT_TICK) begin
                            tick_cnt_reg <= '0;
                            shift_reg    <= shift_reg >> 1;
                            if (bit_cnt_reg == LAST_BIT) begin
                                bit_cnt_reg <= '0;
                                state_reg   <= HAS_PARITY ? PAR : STOP;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + BW'(1);
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + TW'(1);
                        end
                    end
                end
                PAR: begin
                    tx_reg <= par_reg;
                    if (s_tick) begin
                        if (tick_cnt_reg == LAST_BIT_TICK) begin
                            tick_cnt_reg <= '0;
                            state_reg    <= STOP;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + TW'(1);
                        end
                    end
                end
                STOP: begin
                    tx_reg <= 1'b1;
                    if (s_tick) begin
                        if (tick_cnt_reg == LAST_STOP_TICK) begin
                            tick_cnt_reg <= '0;
                            state_reg    <= IDLE;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + TW'(1);
                        end
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Pop is masked by reset so nothing is consumed while held in reset.
    assign fifo_rd      = (state_reg == IDLE) & ~fifo_empty & ~reset;
    assign tx           = tx_reg;
    assign tx_busy      = (state_reg != IDLE);
    // Decoded from registers only: high in the final clk of the stop period,
    // the same clk that hands control back to IDLE.
    assign tx_done_tick = (state_reg == STOP) & s_tick
                        & (tick_cnt_reg == LAST_STOP_TICK);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (no parity / even / odd / 2 stop bits),
// each fed by a small FWFT FIFO stub, checked every clk against a frame-offset
// model, plus hand-computed expectations for the directed scenarios.
module tb_uart_tx;

    localparam int NDUT   = 4;
    localparam int DVSR   = 4;
    localparam int BITCLK = 16 * DVSR;
    localparam int HIST   = 65536;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    logic [NDUT-1:0] fifo_empty, fifo_rd, tx, tx_busy, tx_done_tick;
    logic [7:0]      fifo_data [NDUT];
    logic [7:0]      mem [NDUT][256];
    logic [7:0]      wr_ptr [NDUT];
    logic [7:0]      rd_ptr [NDUT] = '{default: 8'd0};

    int   npass  = 0;
    int   ntotal = 0;

    // Observation logs filled by the compare process.
    int   pop_log  [NDUT][128];
    int   done_log [NDUT][128];
    int   pop_n    [NDUT];
    int   done_n   [NDUT];
    logic tx_hist  [NDUT][HIST];

    // Model state: clks since the pop (0 = idle) and the byte being sent.
    int         t_m [NDUT];
    logic [7:0] fb_m [NDUT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int par_of(int i);
        return (i == 1) ? 2 : (i == 2) ? 1 : 0;
    endfunction

    function automatic int sb_of(int i);
        return (i == 3) ? 32 : 16;
    endfunction

    function automatic int flen(int i);
        return (9 + ((par_of(i) != 0) ? 1 : 0)) * BITCLK + sb_of(i) * DVSR;
    endfunction

    function automatic logic par_bit(int i, logic [7:0] b);
        logic ones_odd;
        ones_odd = (($countones(b) % 2) == 1);
        return (par_of(i) == 2) ? ones_odd : !ones_odd;
    endfunction

    // Line level at clk tt after the pop clk; the line follows the frame
    // one clk late, so the start bit occupies tt = 2 .. 2+BITCLK-1.
    function automatic logic model_tx(int i, logic [7:0] b, int tt);
        int idx;
        if (tt < 2) return 1'b1;
        idx = (tt - 2) / BITCLK;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9 && par_of(i) != 0) return par_bit(i, b);
        return 1'b1;
    endfunction

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        assign fifo_empty[gi] = (wr_ptr[gi] == rd_ptr[gi]);
        assign fifo_data[gi]  = mem[gi][rd_ptr[gi]];
        uart_tx #(
            .DBIT   (8),
            .SB_TICK((gi == 3) ? 32 : 16),
            .PARITY ((gi == 1) ? 2 : (gi == 2) ? 1 : 0),
            .DVSR   (DVSR)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .fifo_empty  (fifo_empty[gi]),
            .fifo_data   (fifo_data[gi]),
            .fifo_rd     (fifo_rd[gi]),
            .tx          (tx[gi]),
            .tx_busy     (tx_busy[gi]),
            .tx_done_tick(tx_done_tick[gi])
        );
    end

    always @(posedge clk) begin
        for (int i = 0; i < NDUT; i++)
            if (fifo_rd[i]) rd_ptr[i] <= rd_ptr[i] + 8'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic [7:0] b);
        mem[i][wr_ptr[i]] = b;
        wr_ptr[i] = wr_ptr[i] + 8'd1;
    endtask

    function automatic logic [7:0] dec_byte(int i, int p);
        logic [7:0] b;
        for (int j = 0; j < 8; j++)
            b[j] = tx_hist[i][(p + 2 + BITCLK * (j + 1) + BITCLK / 2) % HIST];
        return b;
    endfunction

    // Per-clk compare of {fifo_rd, tx, tx_busy, tx_done_tick} for every DUT.
    initial begin
        logic [3:0] exp_v;
        for (int i = 0; i < NDUT; i++) begin
            t_m[i] = 0; fb_m[i] = 8'h00; pop_n[i] = 0; done_n[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                if (reset) begin
                    exp_v  = 4'b0100;
                    t_m[i] = 0;
                end else if (t_m[i] == 0) begin
                    exp_v = {!fifo_empty[i], 3'b100};
                    if (!fifo_empty[i]) begin
                        fb_m[i] = fifo_data[i];
                        t_m[i]  = 1;
                    end
                end else begin
                    exp_v = {1'b0, model_tx(i, fb_m[i], t_m[i]), 1'b1, (t_m[i] == flen(i))};
                    t_m[i] = (t_m[i] == flen(i)) ? 0 : t_m[i] + 1;
                end
                chk($sformatf("d%0d_rd_tx_busy_done", i),
                    {fifo_rd[i], tx[i], tx_busy[i], tx_done_tick[i]}, exp_v);
                tx_hist[i][cyc % HIST] = tx[i];
                if (fifo_rd[i] && pop_n[i] < 128) begin
                    pop_log[i][pop_n[i]] = cyc; pop_n[i]++;
                end
                if (tx_done_tick[i] && done_n[i] < 128) begin
                    done_log[i][done_n[i]] = cyc; done_n[i]++;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1);
    end

    initial begin
        int n0, d0, p, p1, p2, p3, r, zeros, rds, busys, ones, guard;
        logic [9:0] v;
        reset = 1'b1;
        for (int i = 0; i < NDUT; i++) wr_ptr[i] = 8'd0;
        step(4);
        chk("reset_outputs", {fifo_rd[0], tx[0], tx_busy[0], tx_done_tick[0]}, 4'b0100);
        reset = 1'b0;

        // Empty FIFO for 1000 clks after reset: line stays idle.
        zeros = 0; rds = 0; busys = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!tx[0]) zeros++;
            if (fifo_rd[0]) rds++;
            if (tx_busy[0]) busys++;
        end
        chk("idle_tx_low_clks", zeros, 0);
        chk("idle_pops", rds, 0);
        chk("idle_busy_clks", busys, 0);
        step(1);

        // Single frames: 0xA5 plain, 0x07 even/odd parity, 0x55 two stop bits.
        n0 = pop_n[0]; d0 = done_n[0];
        push(0, 8'hA5); push(1, 8'h07); push(2, 8'h07); push(3, 8'h55);
        step(800);
        chk("a5_pop_count", pop_n[0] - n0, 1);
        p = pop_log[0][n0];
        chk("a5_done_latency", done_log[0][d0] - p, 640);
        for (int k = 0; k < 10; k++) v[9-k] = tx_hist[0][(p + 2 + BITCLK / 2 + BITCLK * k) % HIST];
        chk("a5_line_bits", v, 10'b0101001011);
        chk("start_edge_after_pop", {tx_hist[0][(p + 1) % HIST], tx_hist[0][(p + 2) % HIST]}, 2'b10);
        p1 = pop_log[1][pop_n[1] - 1];
        p2 = pop_log[2][pop_n[2] - 1];
        p3 = pop_log[3][pop_n[3] - 1];
        chk("even_parity_bit", tx_hist[1][(p1 + 2 + 9 * BITCLK + BITCLK / 2) % HIST], 1);
        chk("even_frame_len", done_log[1][done_n[1] - 1] - p1, 704);
        chk("odd_parity_bit", tx_hist[2][(p2 + 2 + 9 * BITCLK + BITCLK / 2) % HIST], 0);
        chk("odd_frame_len", done_log[2][done_n[2] - 1] - p2, 704);
        chk("sb32_last_data_bit", tx_hist[3][(p3 + 1 + 9 * BITCLK) % HIST], 0);
        ones = 0;
        for (int k = 0; k < 128; k++) if (tx_hist[3][(p3 + 2 + 9 * BITCLK + k) % HIST]) ones++;
        chk("sb32_stop_high_clks", ones, 128);
        chk("sb32_frame_len", done_log[3][done_n[3] - 1] - p3, 704);

        // Back-to-back frames.
        n0 = pop_n[0]; d0 = done_n[0];
        push(0, 8'h00); push(0, 8'hFF); push(0, 8'h3C);
        step(3 * 641 + 100);
        chk("b2b_pop_count", pop_n[0] - n0, 3);
        chk("b2b_spacing_1", pop_log[0][n0 + 1] - pop_log[0][n0], 641);
        chk("b2b_spacing_2", pop_log[0][n0 + 2] - pop_log[0][n0 + 1], 641);
        chk("b2b_done_to_pop", pop_log[0][n0 + 1] - done_log[0][d0], 1);
        chk("b2b_byte0", dec_byte(0, pop_log[0][n0]), 8'h00);
        chk("b2b_byte1", dec_byte(0, pop_log[0][n0 + 1]), 8'hFF);
        chk("b2b_byte2", dec_byte(0, pop_log[0][n0 + 2]), 8'h3C);

        // Reset 300 clks into a frame; the queued next byte goes out whole.
        push(0, 8'hA5); push(0, 8'h96);
        step(300);
        reset = 1'b1;
        #1;
        chk("midframe_reset_tx", tx[0], 1);
        chk("midframe_reset_busy", tx_busy[0], 0);
        n0 = pop_n[0];
        step(5);
        chk("no_pop_in_reset", pop_n[0] - n0, 0);
        reset = 1'b0;
        r = cyc;
        d0 = done_n[0];
        step(700);
        chk("post_reset_pop_count", pop_n[0] - n0, 1);
        chk("post_reset_pop_clk", pop_log[0][n0] - r, 0);
        chk("post_reset_byte", dec_byte(0, pop_log[0][n0]), 8'h96);
        chk("post_reset_frame_len", done_log[0][d0] - pop_log[0][n0], 640);

        // Random traffic on all instances, with one reset part way through.
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < NDUT; i++)
                if ($urandom_range(0, 1) == 1) push(i, 8'($urandom));
            if (it == 15) begin
                reset = 1'b1;
                step(3);
                reset = 1'b0;
            end
            step($urandom_range(1, 700));
        end
        guard = 0;
        while (guard < 30000 && (fifo_empty != {NDUT{1'b1}} || tx_busy != '0)) begin
            step(1);
            guard++;
        end
        chk("random_drain_in_time", (guard < 30000), 1);
        step(2);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
